// File: rtl/instr_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// instr_buffer_ctrl
//   Instruction buffer with per-entry valid tracking, feeding fetch/decode.
//   Two run-time modes selected by seq_mode:
//     0 : indexed    - random-access write/read by slot index
//     1 : sequential - circular FIFO with auto-advancing pointers,
//                      full/empty flags and sticky overflow/underflow
//   All-zero words are null instructions and never mark an entry valid.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   seq_mode             mode select (a change acts as a flush on that edge)
//   flush                synchronous invalidate of entries and pointers
//   wr_en/wr_index/wr_data  write request (index used in indexed mode only)
//   rd_en/rd_index       read request (index used in indexed mode only)
//   rd_data/rd_valid     registered read result (1-cycle latency)
//   occupancy            indexed: valid-bit popcount; sequential: fill level
//   full, empty          fill status (full only meaningful in sequential mode)
//   overflow, underflow  sticky error flags, cleared only by reset
//
// Request/response semantics: there is no back-pressure. A request is a
// single-cycle rd_en/wr_en pulse sampled on the rising edge. Every rd_en
// updates rd_valid on that edge (rd_data only when the read is serviced);
// with rd_en low both outputs hold. A refused sequential request is not
// retried by the buffer; it only raises the corresponding sticky flag.
// -----------------------------------------------------------------------------
module instr_buffer_ctrl #(
  parameter  int INSTR_W = 16,
  parameter  int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seq_mode,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_index,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_index,
  output logic [INSTR_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [AW:0]        occupancy,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   OCC_ONE   = 1;
  localparam logic [AW:0]   OCC_DEPTH = (AW+1)'(DEPTH);

  // Registered state
  logic               r_mode;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_occ;
  logic [INSTR_W-1:0] r_rd_data;
  logic               r_rd_valid;
  logic               r_ovf;
  logic               r_unf;

  // Next-state / control wires
  logic [DEPTH-1:0]   w_valid_nxt;
  logic [AW-1:0]      w_wr_ptr_nxt;
  logic [AW-1:0]      w_rd_ptr_nxt;
  logic [AW:0]        w_occ_nxt;
  logic [INSTR_W-1:0] w_rd_data_nxt;
  logic               w_rd_valid_nxt;
  logic               w_ovf_nxt;
  logic               w_unf_nxt;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_mem_we;
  logic [AW-1:0]      w_mem_waddr;

  function automatic logic [AW:0] f_popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  // A mode change flushes on the edge where it is seen; the registered
  // mode then selects behaviour from the following cycle onwards.
  assign w_flush = flush || (seq_mode != r_mode);

  // Full/empty come from the wide occupancy counter, so pointer equality
  // is never ambiguous.
  assign w_full  = r_mode && (r_occ == OCC_DEPTH);
  assign w_empty = (r_occ == '0);

  always_comb begin
    w_valid_nxt    = r_valid;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_occ_nxt      = r_occ;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = r_rd_valid;
    w_ovf_nxt      = r_ovf;
    w_unf_nxt      = r_unf;
    w_wr_acc       = 1'b0;
    w_rd_acc       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_waddr    = r_mode ? r_wr_ptr : wr_index;

    if (w_flush) begin
      // Flush wins over any same-cycle request; rd_data is left as is.
      w_valid_nxt    = '0;
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_occ_nxt      = '0;
      w_rd_valid_nxt = 1'b0;
    end else if (!r_mode) begin
      // Indexed: the read uses current state, so a same-index write in
      // the same cycle is observed only by later reads.
      if (rd_en) begin
        w_rd_data_nxt  = r_mem[rd_index];
        w_rd_valid_nxt = r_valid[rd_index];
      end
      if (wr_en) begin
        w_mem_we              = 1'b1;
        w_valid_nxt[wr_index] = |wr_data;
      end
      w_occ_nxt = f_popcount(w_valid_nxt);
    end else begin
      w_rd_acc = rd_en && !w_empty;
      // A read in the same cycle frees the slot a full buffer needs.
      w_wr_acc = wr_en && (!w_full || w_rd_acc);

      if (rd_en) begin
        if (w_rd_acc) begin
          w_rd_data_nxt         = r_mem[r_rd_ptr];
          w_rd_valid_nxt        = r_valid[r_rd_ptr];
          w_valid_nxt[r_rd_ptr] = 1'b0;
          w_rd_ptr_nxt          = r_rd_ptr + PTR_ONE;
        end else begin
          w_rd_valid_nxt = 1'b0;
          w_unf_nxt      = 1'b1;
        end
      end

      // Applied after the read clear: when full, both pointers address
      // the same slot and the new word's valid bit must win.
      if (wr_en) begin
        if (w_wr_acc) begin
          w_mem_we              = 1'b1;
          w_valid_nxt[r_wr_ptr] = |wr_data;
          w_wr_ptr_nxt          = r_wr_ptr + PTR_ONE;
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_occ_nxt = r_occ + OCC_ONE;
        2'b01:   w_occ_nxt = r_occ - OCC_ONE;
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_valid    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_mode     <= seq_mode;
      r_valid    <= w_valid_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_occ      <= w_occ_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_ovf      <= w_ovf_nxt;
      r_unf      <= w_unf_nxt;
    end
  end

  // Storage has no reset; validity is tracked entirely by r_valid.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= wr_data;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign occupancy = r_occ;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_instr_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_buffer_ctrl
//   Directed bench for instr_buffer_ctrl (INSTR_W=16, DEPTH=16).
//   Driver tasks push expected read responses into exp_q when a read is
//   issued and expected output snapshots into st_q right after an edge;
//   the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_buffer_ctrl;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          seq_mode;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_index;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_index;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [AW:0]   occupancy;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  instr_buffer_ctrl #(.INSTR_W(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_mode  (seq_mode),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {check_data, data[15:0], valid}
  logic [17:0] exp_q[$];
  // st_q entry: {data[15:0], valid, occ[4:0], full, empty, ovf, unf}
  logic [25:0] st_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rd_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_en;
  end

  always @(negedge clk) begin : monitor
    logic [17:0] e;
    logic [25:0] s;
    logic [25:0] a;
    if (rd_pend) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_resp: got data=%h valid=%b, required no response", rd_data, rd_valid);
      end else begin
        e = exp_q.pop_front();
        if (rd_valid !== e[0] || (e[17] && rd_data !== e[16:1])) begin
          n_err++;
          $display("FAIL rd_resp: got data=%h valid=%b, required data=%h valid=%b (data checked=%b)",
                   rd_data, rd_valid, e[16:1], e[0], e[17]);
        end
      end
    end
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      a = {rd_data, rd_valid, occupancy, full, empty, overflow, underflow};
      n_cmp++;
      if (a !== s) begin
        n_err++;
        $display("FAIL status: got data=%h v=%b occ=%0d full=%b empty=%b ovf=%b unf=%b, required data=%h v=%b occ=%0d full=%b empty=%b ovf=%b unf=%b",
                 a[25:10], a[9], a[8:4], a[3], a[2], a[1], a[0],
                 s[25:10], s[9], s[8:4], s[3], s[2], s[1], s[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [AW-1:0] wi, input logic [W-1:0] wd,
                      input logic re, input logic [AW-1:0] ri, input logic fl);
    wr_en    = we;
    wr_index = wi;
    wr_data  = wd;
    rd_en    = re;
    rd_index = ri;
    flush    = fl;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic exp_rd(input logic chk, input logic [W-1:0] d, input logic v);
    exp_q.push_back({chk, d, v});
  endtask

  task automatic exp_st(input logic [W-1:0] d, input logic v, input logic [AW:0] occ,
                        input logic f, input logic e, input logic o, input logic u);
    st_q.push_back({d, v, occ, f, e, o, u});
  endtask

  task automatic iw(input logic [AW-1:0] idx, input logic [W-1:0] d);
    step(1'b1, idx, d, 1'b0, '0, 1'b0);
  endtask

  task automatic ir(input logic [AW-1:0] idx, input logic chk, input logic [W-1:0] d, input logic v);
    exp_rd(chk, d, v);
    step(1'b0, '0, '0, 1'b1, idx, 1'b0);
  endtask

  task automatic sw(input logic [W-1:0] d);
    step(1'b1, '0, d, 1'b0, '0, 1'b0);
  endtask

  task automatic sr(input logic [W-1:0] d, input logic v);
    exp_rd(1'b1, d, v);
    step(1'b0, '0, '0, 1'b1, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    seq_mode = 1'b0;
    flush    = 1'b0;
    wr_en    = 1'b0;
    wr_index = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_index = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    exp_st(16'h0000, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Indexed write/readback and null write
    iw(3, 16'h1234);            exp_st(16'h0000, 0, 1, 0, 0, 0, 0);
    ir(3, 1, 16'h1234, 1);      exp_st(16'h1234, 1, 1, 0, 0, 0, 0);
    iw(3, 16'h0000);            exp_st(16'h1234, 1, 0, 0, 1, 0, 0);
    ir(3, 1, 16'h0000, 0);      exp_st(16'h0000, 0, 0, 0, 1, 0, 0);

    // Indexed collision: read-before-write
    iw(5, 16'hAAAA);
    exp_rd(1, 16'hAAAA, 1);
    step(1, 5, 16'hBBBB, 1, 5, 0);
    exp_st(16'hAAAA, 1, 1, 0, 0, 0, 0);
    ir(5, 1, 16'hBBBB, 1);

    // Boundary indices, reads never clear valid bits
    iw(15, 16'hF00F);
    iw(0, 16'h0F0F);            exp_st(16'hBBBB, 1, 3, 0, 0, 0, 0);
    ir(15, 1, 16'hF00F, 1);
    ir(0, 1, 16'h0F0F, 1);
    ir(5, 1, 16'hBBBB, 1);      exp_st(16'hBBBB, 1, 3, 0, 0, 0, 0);

    // Enter sequential mode: implicit flush on the switching edge
    seq_mode = 1'b1;
    step(0, 0, 0, 0, 0, 0);     exp_st(16'hBBBB, 0, 0, 0, 1, 0, 0);

    // FIFO fill
    for (int i = 1; i <= 16; i++) sw(16'(i));
    exp_st(16'hBBBB, 0, 16, 1, 0, 0, 0);
    sw(16'h0099);               exp_st(16'hBBBB, 0, 16, 1, 0, 1, 0);

    // Read+write while full: write accepted
    exp_rd(1, 16'h0001, 1);
    step(1, 0, 16'h0011, 1, 0, 0);
    exp_st(16'h0001, 1, 16, 1, 0, 1, 0);

    // Drain in order
    for (int i = 2; i <= 16; i++) sr(16'(i), 1);
    sr(16'h0011, 1);            exp_st(16'h0011, 1, 0, 0, 1, 1, 0);

    // Underflow: rd_data holds, rd_valid drops
    sr(16'h0011, 0);            exp_st(16'h0011, 0, 0, 0, 1, 1, 1);

    // Null word occupies a slot, returned invalid
    sw(16'h0000);
    sw(16'h0022);               exp_st(16'h0011, 0, 2, 0, 0, 1, 1);
    sr(16'h0000, 0);
    sr(16'h0022, 1);            exp_st(16'h0022, 1, 0, 0, 1, 1, 1);

    // Wrap with simultaneous read/write at occupancy 15
    for (int k = 0; k < 15; k++) sw(16'h0100 + 16'(k));
    exp_st(16'h0022, 1, 15, 0, 0, 1, 1);
    for (int j = 0; j < 40; j++) begin
      exp_rd(1, 16'h0100 + 16'(j), 1);
      step(1, 0, 16'h010F + 16'(j), 1, 0, 0);
    end
    exp_st(16'h0127, 1, 15, 0, 0, 1, 1);
    for (int j = 40; j < 48; j++) sr(16'h0100 + 16'(j), 1);
    exp_st(16'h012F, 1, 7, 0, 0, 1, 1);

    // Flush priority at occupancy 7
    exp_rd(1, 16'h012F, 0);
    step(1, 0, 16'h5555, 1, 0, 1);
    exp_st(16'h012F, 0, 0, 0, 1, 1, 1);
    sw(16'h0301);
    sr(16'h0301, 1);            exp_st(16'h0301, 1, 0, 0, 1, 1, 1);

    // Mode toggle behaves as flush
    for (int k = 1; k <= 7; k++) sw(16'h0200 + 16'(k));
    exp_st(16'h0301, 1, 7, 0, 0, 1, 1);
    seq_mode = 1'b0;
    exp_rd(1, 16'h0301, 0);
    step(1, 2, 16'h7777, 1, 2, 0);
    exp_st(16'h0301, 0, 0, 0, 1, 1, 1);
    ir(2, 0, 16'h0000, 0);
    iw(4, 16'h4444);
    ir(4, 1, 16'h4444, 1);      exp_st(16'h4444, 1, 1, 0, 0, 1, 1);

    // Asynchronous reset between edges during a write burst
    wr_en    = 1'b1;
    wr_index = 1;
    wr_data  = 16'h3333;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    exp_st(16'h0000, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ir(4, 0, 16'h0000, 0);
    ir(1, 0, 16'h0000, 0);

    // Drain checks, then make sure nothing expected was left unconsumed
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d reads and %0d snapshots pending, required 0 and 0",
               exp_q.size(), st_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_buffer_ctrl.md
Name: instr_buffer_ctrl

Overview:
- Parametrised instruction buffer with per-entry valid tracking. Feeds the fetch/decode path of the ESM core.
- Two run-time modes:
  - Indexed mode: random-access write/read by slot index.
  - Sequential mode: circular FIFO with auto-advancing pointers, full/empty flags and sticky error flags.
- All-zero instruction words are null instructions; they never mark an entry valid.

Parameters:
- INSTR_W, 16, instruction word width in bits.
- DEPTH, 16, number of entries; power of two, >= 2.
- AW, $clog2(DEPTH), index/pointer width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seq_mode  in  1  0 = indexed mode, 1 = sequential (FIFO) mode.
- flush  in  1  synchronous invalidate of all entries and pointers.
- wr_en  in  1  write request.
- wr_index  in  AW  write slot (indexed mode only).
- wr_data  in  INSTR_W  instruction to store.
- rd_en  in  1  read request.
- rd_index  in  AW  read slot (indexed mode only).
- rd_data  out  INSTR_W  registered read data.
- rd_valid  out  1  rd_data holds a valid (non-null) instruction.
- occupancy  out  AW+1  indexed: popcount of valid bits; sequential: FIFO fill level.
- full  out  1  sequential mode: occupancy == DEPTH; 0 in indexed mode.
- empty  out  1  occupancy == 0.
- overflow  out  1  sticky: write attempted while full (sequential mode).
- underflow  out  1  sticky: read attempted while empty (sequential mode).

Behaviour:
- Reset (rst_n low, async):
  - rd_data=0, rd_valid=0; all valid bits=0.
  - wr_ptr=rd_ptr=0, occupancy=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage array is not reset.
- Read latency is 1 cycle. rd_data/rd_valid update on the edge after rd_en; they hold their values when rd_en=0.
- Indexed mode (seq_mode=0):
  - On wr_en: mem[wr_index]<=wr_data; valid[wr_index]<=(wr_data!=0).
  - On rd_en: rd_data<=mem[rd_index]; rd_valid<=valid[rd_index].
  - Read and write to the same index in the same cycle is read-before-write: the old data and old valid bit are returned.
  - Reads never clear valid bits.
  - occupancy = count of set valid bits, registered, reflecting the state after the edge.
- Sequential mode (seq_mode=1); wr_index/rd_index are ignored:
  - Write accepted iff wr_en && (!full || rd_en_accepted). Accepted write stores at mem[wr_ptr], sets valid[wr_ptr]=(wr_data!=0), wr_ptr<=wr_ptr+1 mod DEPTH.
  - Read accepted iff rd_en && !empty. Accepted read:
    - rd_data<=mem[rd_ptr], rd_valid<=valid[rd_ptr].
    - valid[rd_ptr]<=0 (consumed), rd_ptr<=rd_ptr+1 mod DEPTH.
  - Null words occupy a slot and are returned with rd_valid=0.
  - Simultaneous accepted read and write leaves occupancy unchanged. When full, a same-cycle read frees a slot, so the write is accepted.
  - Write while full with no read: write dropped, overflow<=1.
  - Read while empty: rd_valid<=0, rd_data holds its previous value, underflow<=1.
  - Pointers wrap from DEPTH-1 to 0; full/empty are derived from the AW+1-bit occupancy, not from pointer equality.
- Mode change: a change of seq_mode (registered copy differs from input) acts as an implicit flush on that edge, and the new mode applies from the following cycle.
- flush:
  - Clears all valid bits, wr_ptr, rd_ptr, occupancy and rd_valid; sets empty=1.
  - Leaves overflow/underflow untouched; they are cleared only by reset.
  - flush takes priority over any same-cycle wr_en/rd_en, which are dropped.
- Reset asserted mid-operation takes effect immediately, regardless of the clock.

Test Plan:
- Indexed write/readback: write 0x1234 to idx 3, then rd idx 3 -> next cycle rd_data=0x1234, rd_valid=1, occupancy=1. Write 0x0000 to idx 3 -> rd_valid=0, occupancy=0.
- Indexed collision: idx 5 holds 0xAAAA; same cycle wr idx 5 = 0xBBBB and rd idx 5 -> rd_data=0xAAAA; next read -> 0xBBBB.
- FIFO fill/drain (DEPTH=16): 16 writes 0x0001..0x0010 -> full=1, occupancy=16. A 17th write -> dropped, overflow=1. 16 reads -> data 0x0001..0x0010 in order, empty=1. One more read -> underflow=1, rd_valid=0.
- FIFO wrap with simultaneous read/write: hold occupancy at 15 and issue rd_en+wr_en for 40 cycles -> occupancy stays 15, output sequence is in order and unbroken, pointers wrap at least twice.
- Flush priority: flush=1 with wr_en=1 and rd_en=1 at occupancy 7 -> next cycle occupancy=0, empty=1, rd_valid=0, sticky flags unchanged. Toggling seq_mode has the same effect.
- Async reset: assert rst_n=0 mid-burst between clock edges -> all outputs at reset values immediately. Deassert, then indexed read of any index -> rd_valid=0.
